// File: rtl/ea_sequencer_pkg.sv
// Shared definitions for the effective-address sequencer: opcodes, FSM
// states and the operand-select enumerations used by decode.
package ea_sequencer_pkg;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RSV  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_IND  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    SEL_NONE  = 3'd0,
    SEL_OFF6  = 3'd1,
    SEL_OFF9  = 3'd2,
    SEL_OFF11 = 3'd3,
    SEL_TRAP8 = 3'd4
  } off_sel_e;

  // Which register supplies the base term of the address sum.
  typedef enum logic [1:0] {
    BASE_ZERO = 2'd0,
    BASE_PC   = 2'd1,
    BASE_REG  = 2'd2
  } base_sel_e;

endpackage

// File: rtl/ea_sequencer_if.sv
// Request/response and indirect-read signals of the EA sequencer.
// slave: the sequencer side; master: the requester/memory side.
interface ea_sequencer_if #(parameter int WIDTH = 16);
  logic             start;
  logic [WIDTH-1:0] ir;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] base;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ea;
  logic             illegal;
  logic             mem_req;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ready;

  modport slave (
    input  start, ir, pc, base, mem_rdata, mem_ready,
    output busy, done, ea, illegal, mem_req, mem_addr
  );

  modport master (
    output start, ir, pc, base, mem_rdata, mem_ready,
    input  busy, done, ea, illegal, mem_req, mem_addr
  );
endinterface

// File: rtl/ea_sequencer_offset_ext.sv
// Offset term of the EA sum: extends the selected immediate field of ir
// to WIDTH bits. Signed fields are sign-extended, the trap vector is
// zero-extended so vectors 0x80-0xFF stay in the low page.
module offset_ext
  import ea_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] ir_i,
  input  off_sel_e         sel_i,
  output logic [WIDTH-1:0] off_o
);

  // Upper instruction bits never feed an offset field.
  logic unused_ir_hi;
  assign unused_ir_hi = ^ir_i[WIDTH-1:11];

  // Select and extend the immediate field.
  always_comb begin
    off_o = '0;
    unique case (sel_i)
      SEL_OFF6:  off_o = {{(WIDTH-6){ir_i[5]}},   ir_i[5:0]};
      SEL_OFF9:  off_o = {{(WIDTH-9){ir_i[8]}},   ir_i[8:0]};
      SEL_OFF11: off_o = {{(WIDTH-11){ir_i[10]}}, ir_i[10:0]};
      SEL_TRAP8: off_o = {{(WIDTH-8){1'b0}},      ir_i[7:0]};
      default:   off_o = '0;
    endcase
  end

endmodule

// File: rtl/ea_sequencer.sv
// Effective-address sequencer. Captures an instruction with its PC and
// base register on start, computes the EA in one cycle, and for
// indirect opcodes performs one memory read whose data becomes the EA.
//
// state  | meaning
// IDLE   | waiting for start; only state that accepts a request
// CALC   | decode captured ir and form base + offset
// IND    | indirect read outstanding (mem_req high) until mem_ready
// DONE   | one-cycle done pulse; ea/illegal valid
module ea_sequencer
  import ea_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic          clk,
  input logic          rst,
  ea_sequencer_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ir_q, pc_q, base_q;
  logic [WIDTH-1:0] ea_q, mem_addr_q;
  logic             illegal_q;

  base_sel_e        dec_base_sel;
  off_sel_e         dec_off_sel;
  logic             dec_indirect;
  logic             dec_illegal;
  logic [WIDTH-1:0] base_term;
  logic [WIDTH-1:0] off_term;
  logic [WIDTH-1:0] calc_ea;
  logic [3:0]       opcode;

  assign opcode = ir_q[15:12];

  // Opcode decode into base select, offset select and routing flags.
  always_comb begin
    dec_base_sel = BASE_ZERO;
    dec_off_sel  = SEL_NONE;
    dec_indirect = 1'b0;
    dec_illegal  = 1'b0;
    unique case (opcode)
      OP_BR, OP_LD, OP_ST, OP_LEA: begin
        dec_base_sel = BASE_PC;
        dec_off_sel  = SEL_OFF9;
      end
      OP_LDI, OP_STI: begin
        dec_base_sel = BASE_PC;
        dec_off_sel  = SEL_OFF9;
        dec_indirect = 1'b1;
      end
      OP_LDR, OP_STR: begin
        dec_base_sel = BASE_REG;
        dec_off_sel  = SEL_OFF6;
      end
      OP_JSR: begin
        if (ir_q[11]) begin
          dec_base_sel = BASE_PC;
          dec_off_sel  = SEL_OFF11;
        end else begin
          dec_base_sel = BASE_REG;
        end
      end
      OP_JMP: dec_base_sel = BASE_REG;
      OP_TRAP: begin
        dec_off_sel  = SEL_TRAP8;
        dec_indirect = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Base term mux.
  always_comb begin
    base_term = '0;
    unique case (dec_base_sel)
      BASE_PC:  base_term = pc_q;
      BASE_REG: base_term = base_q;
      default:  base_term = '0;
    endcase
  end

  offset_ext #(.WIDTH(WIDTH)) u_offset_ext (
    .ir_i  (ir_q),
    .sel_i (dec_off_sel),
    .off_o (off_term)
  );

  // Carry out of the top bit is intentionally dropped (address wrap).
  assign calc_ea = base_term + off_term;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.start) state_d = S_CALC;
      S_CALC: state_d = (dec_indirect && !dec_illegal) ? S_IND : S_DONE;
      S_IND:  if (bus.mem_ready) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture on an accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q   <= '0;
      pc_q   <= '0;
      base_q <= '0;
    end else if (state_q == S_IDLE && bus.start) begin
      ir_q   <= bus.ir;
      pc_q   <= bus.pc;
      base_q <= bus.base;
    end
  end

  // Result registers: ea/illegal change only on entry to DONE, so they
  // hold between done pulses; mem_addr is loaded on entry to IND.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ea_q       <= '0;
      mem_addr_q <= '0;
      illegal_q  <= 1'b0;
    end else begin
      if (state_q == S_CALC) begin
        if (dec_illegal) begin
          ea_q      <= '0;
          illegal_q <= 1'b1;
        end else if (dec_indirect) begin
          mem_addr_q <= calc_ea;
        end else begin
          ea_q      <= calc_ea;
          illegal_q <= 1'b0;
        end
      end else if (state_q == S_IND && bus.mem_ready) begin
        ea_q      <= bus.mem_rdata;
        illegal_q <= 1'b0;
      end
    end
  end

  // Status outputs decode straight from state so reset clears them at once.
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.mem_req  = (state_q == S_IND);
  assign bus.ea       = ea_q;
  assign bus.illegal  = illegal_q;
  assign bus.mem_addr = mem_addr_q;

endmodule

// File: doc/ea_sequencer.md
EA_SEQUENCER -- requirements
Module: ea_sequencer

Interface
REQ-001 Parameter: WIDTH, 16, datapath/address width.
REQ-002 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  in  1  reset; asynchronous and active-high.
REQ-004 Port: start  in  1  one-cycle request to compute an effective address (EA) for ir.
REQ-005 Port: ir  in  WIDTH  instruction word; sampled on accepted start.
REQ-006 Port: pc  in  WIDTH  incremented PC; sampled on accepted start.
REQ-007 Port: base  in  WIDTH  BaseR/SR1 register value; sampled on accepted start.
REQ-008 Port: busy  out  1  high from the cycle after an accepted start until done.
REQ-009 Port: done  out  1  one-cycle pulse; ea and illegal valid while high.
REQ-010 Port: ea  out  WIDTH  final effective address; holds its value until the next done.
REQ-011 Port: illegal  out  1  opcode has no EA; valid with done.
REQ-012 Port: mem_req  out  1  indirect read request; held until mem_ready.
REQ-013 Port: mem_addr  out  WIDTH  indirect read address; stable while mem_req is high.
REQ-014 Port: mem_rdata  in  WIDTH  read data; valid when mem_ready is high.
REQ-015 Port: mem_ready  in  1  read completion; accepted only while mem_req is high.

Function
REQ-016 States: IDLE, CALC, IND, DONE; start is accepted only in IDLE and ignored otherwise.
REQ-017 Accepted start: capture ir/pc/base; IDLE->CALC.
REQ-018 CALC computes the EA as the sum of a base term and an offset term (modulo 2^WIDTH, carry discarded).
- BR 0000, LD 0010, ST 0011, LEA 1110: pc + sext(ir[8:0]).
- LDI 1010, STI 1011: pc + sext(ir[8:0]), indirect.
- LDR 0110, STR 0111: base + sext(ir[5:0]).
- JSR 0100 with ir[11]=1: pc + sext(ir[10:0]).
- JSRR 0100 with ir[11]=0, JMP/RET 1100: base + 0.
- TRAP 1111: zext(ir[7:0]), indirect.
REQ-019 Opcodes 0001, 0101, 1001, 1000, 1101: CALC->DONE with illegal=1, ea=0, and no mem_req.
REQ-020 Direct opcodes: CALC->DONE; done is high exactly 2 cycles after the start cycle.
REQ-021 Indirect opcodes: CALC->IND; mem_req=1 and mem_addr=computed EA from the IND entry cycle onward.
REQ-022 In IND, mem_ready=1 loads ea<=mem_rdata and moves to DONE, dropping mem_req the same edge; absent mem_ready, IND holds indefinitely.
REQ-023 If mem_ready is already high on the first IND cycle, it completes in that cycle; minimum indirect latency is 3 cycles from start to done.
REQ-024 DONE->IDLE unconditionally; a start in the DONE cycle is ignored; the earliest next accept is the cycle after done.
REQ-025 mem_ready while mem_req=0 has no effect; mem_rdata is ignored outside IND.

Reset
REQ-026 rst=1 forces IDLE immediately, regardless of clk; busy, done, mem_req and illegal go to 0, and ea and mem_addr go to 0.
REQ-027 Reset during IND abandons the read: mem_req drops asynchronously, and a later mem_ready is ignored.
REQ-028 The first start is accepted on the first rising edge after rst deasserts.

Structure
REQ-029 A shared package holds: opcode constants, the state enumeration, and the offset-select enumeration (NONE, OFF6, OFF9, OFF11, TRAP8).
REQ-030 One sub-module, offset_ext: from ir and the offset select, it produces the WIDTH-bit offset term.
- Sign-extends OFF6, OFF9 and OFF11.
- Zero-extends TRAP8.
- Produces 0 for NONE.
REQ-031 Decode and offset_ext are combinational; only state, captured operands, ea, mem_addr and illegal are registered.

Verification
REQ-032 LD: pc=0x3001, ir=0x21FF, start -> done 2 cycles later, ea=0x3000, illegal=0; mem_req never high.
REQ-033 LDR: base=0x4000, ir=0x6A45 -> ea=0x4005; pc=0xFFFF, ir=0x0E02 (BR) -> ea=0x0001 (wrap).
REQ-034 LDI: pc=0x3000, ir=0xA002; mem_ready low for 3 cycles, then high with rdata=0x5000.
- mem_addr=0x3002 is held for 4 cycles.
- ea=0x5000 on done.
- start pulses during busy are ignored.
REQ-035 TRAP: ir=0xF0FF -> mem_addr=0x00FF (not 0xFFFF); with mem_ready=1 immediately, rdata=0x0400 gives ea=0x0400 and done 3 cycles after start.
REQ-036 ADD: ir=0x1021 -> done 2 cycles later with illegal=1, ea=0; JSRR ir=0x4080 with base=0x1234 -> ea=0x1234.
REQ-037 rst asserted mid-clock during IND -> mem_req and busy fall before the next edge; then mem_ready=1 gives no done; a fresh LD completes normally.
